moore_pattern_detector: RTL and testbench
=========================================

MOORE_PATTERN_DETECTOR -- requirements
Module: moore_pattern_detector

Interface
REQ-001 SHALL have parameter PATTERN_W, default 4: pattern length in bits, legal 2..16.
REQ-002 SHALL have parameter DEFAULT_PATTERN, default 4'b1011: pattern value loaded at reset.
REQ-003 SHALL have parameter CNT_W, default 8: match counter width.
REQ-004 SHALL have port Clock  in  1  single clock, rising edge.
REQ-005 SHALL have port Reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port Din  in  1  serial data bit.
REQ-007 SHALL have port En  in  1  Din sampled only when high.
REQ-008 SHALL have port Load  in  1  one-cycle pulse that captures Pattern and restarts detection.
REQ-009 SHALL have port Pattern  in  PATTERN_W  new pattern; bit PATTERN_W-1 is the first bit expected.
REQ-010 SHALL have port Overlap  in  1  1 = overlapping detection, 0 = non-overlapping.
REQ-011 SHALL have port Y  out  1  Moore match flag.
REQ-012 SHALL have port State  out  clog2(PATTERN_W+1)  current match length, 0..PATTERN_W.
REQ-013 SHALL have port MatchCount  out  CNT_W  number of detected matches, saturating.

Function
REQ-014 SHALL hold an internal pattern register P and a state register S, where S is the number of leading pattern bits currently matched, S0..S(PATTERN_W).
REQ-015 SHALL treat a bit as accepted on a rising edge with En=1, Load=0, Reset=0; all other edges SHALL hold S, Y and MatchCount.
REQ-016 On an accepted bit b from state k<PATTERN_W, next S SHALL be the largest j<=k+1 such that the last j accepted bits since the last restart equal P's first j bits; j=0 if none.
REQ-017 From S(PATTERN_W) with Overlap=1, next S SHALL follow REQ-016 with k=PATTERN_W, so the matched pattern's suffix may seed the next match.
REQ-018 From S(PATTERN_W) with Overlap=0, history SHALL be discarded: next S = 1 if b equals P's first bit, else 0.
REQ-019 Y SHALL be 1 exactly when S = PATTERN_W, decoded from the state register only and never combinationally from Din.
REQ-020 Latency: Y SHALL rise in the cycle after the edge that accepts the completing bit.
REQ-021 MatchCount SHALL increment by 1 on each accepted bit whose next S is PATTERN_W, and SHALL saturate at 2^CNT_W-1.
REQ-022 For self-overlapping patterns (e.g. 1111) with Overlap=1, S may remain PATTERN_W; Y SHALL stay high, and MatchCount SHALL increment on every such accepted bit.
REQ-023 Load=1 SHALL capture Pattern into P and set S=0 and Y=0 on the same edge. MatchCount SHALL be unchanged. Din SHALL be ignored that cycle. Load SHALL have priority over En.
REQ-024 A change on Overlap SHALL take effect only at the next transition out of S(PATTERN_W) and SHALL NOT alter S by itself.
REQ-025 State SHALL equal the S register at all times.

Reset
REQ-026 Reset=1 at a rising edge SHALL set S=0, Y=0, MatchCount=0 and P=DEFAULT_PATTERN, with priority over Load and En.
REQ-027 Reset asserted mid-match SHALL discard all history; the first bit accepted after release SHALL be evaluated from S0.

Verification
REQ-028 Overlap test: reset, Overlap=1, En=1, Din=1,0,1,1,0,1,1 -> Y high after the 4th and 7th bits, MatchCount=2.
REQ-029 Non-overlap test: same stream with Overlap=0 -> Y high only after the 4th bit, State=1 after the 7th bit, MatchCount=1.
REQ-030 Enable-gap test: Din=1,0 then En=0 for 5 cycles with Din toggling, then En=1 with Din=1,1 -> State holds 2 through the gap, Y high after the final bit.
REQ-031 Load test: after Din=1,0,1 pulse Load with Pattern=4'b0110, then Din=0,1,1,0 -> State=0 after Load, Y high after the 4th bit, MatchCount preserved.
REQ-032 Saturation test: CNT_W=2, Pattern=1111, Overlap=1, Din=1 for 10 accepted bits -> Y high from the 4th bit onward, MatchCount stops at 3.
REQ-033 Reset-mid-operation test: Reset asserted at State=3 and released, then Din=1 -> State=1, Y=0, MatchCount=0, P=4'b1011.

Source files
------------

// File: rtl/moore_pattern_detector.sv
// Serial Moore pattern detector with a run-time loadable pattern, selectable
// overlapping/non-overlapping detection and a saturating match counter.
// S counts how many leading pattern bits are currently matched; Y is decoded
// from S only, so it never depends combinationally on Din.
module moore_pattern_detector #(
    parameter int unsigned            PATTERN_W       = 4,
    parameter logic [PATTERN_W-1:0]   DEFAULT_PATTERN = PATTERN_W'(4'b1011),
    parameter int unsigned            CNT_W           = 8
) (
    input  logic                               Clock,
    input  logic                               Reset,
    input  logic                               Din,
    input  logic                               En,
    input  logic                               Load,
    input  logic [PATTERN_W-1:0]               Pattern,
    input  logic                               Overlap,
    output logic                               Y,
    output logic [$clog2(PATTERN_W+1)-1:0]     State,
    output logic [CNT_W-1:0]                   MatchCount
);

    localparam int unsigned       SW      = $clog2(PATTERN_W + 1);
    localparam logic [SW-1:0]     S_FULL  = SW'(PATTERN_W);
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;

    logic [PATTERN_W-1:0] p_q;
    logic [SW-1:0]        s_q,   s_d;
    logic [PATTERN_W-1:0] h_q,   h_d;
    logic                 y_q,   y_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    // Most recent PATTERN_W accepted bits including the incoming one (bit 0 newest).
    // Only the newest S+1 bits are ever consulted, and the current S bits are
    // known to equal the pattern prefix, so stale history never leaks into a match.
    assign h_d = {h_q[PATTERN_W-2:0], Din};

    // Next match length for an accepted bit: longest pattern prefix that is a suffix of the window.
    always_comb begin : next_state
        logic [PATTERN_W-1:0] mask;
        logic [PATTERN_W-1:0] prefix;
        s_d = '0;
        for (int j = 1; j <= int'(PATTERN_W); j++) begin
            mask   = {PATTERN_W{1'b1}} >> (int'(PATTERN_W) - j);
            prefix = p_q >> (int'(PATTERN_W) - j);
            if ((j <= int'(s_q) + 1) && ((h_d & mask) == (prefix & mask))) begin
                s_d = SW'(j);
            end
        end
        // Non-overlapping mode forgets the completed match entirely.
        if ((s_q == S_FULL) && !Overlap) begin
            s_d = (Din == p_q[PATTERN_W-1]) ? SW'(1) : '0;
        end
    end

    // Match flag and saturating count that follow an accepted bit.
    always_comb begin : next_outputs
        y_d   = (s_d == S_FULL);
        cnt_d = cnt_q;
        if (y_d && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State, pattern, history and output registers; reset beats Load beats En.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            p_q   <= DEFAULT_PATTERN;
            s_q   <= '0;
            h_q   <= '0;
            y_q   <= 1'b0;
            cnt_q <= '0;
        end else if (Load) begin
            p_q   <= Pattern;
            s_q   <= '0;
            h_q   <= '0;
            y_q   <= 1'b0;
        end else if (En) begin
            s_q   <= s_d;
            h_q   <= h_d;
            y_q   <= y_d;
            cnt_q <= cnt_d;
        end
    end

    assign Y          = y_q;
    assign State      = s_q;
    assign MatchCount = cnt_q;

endmodule

// File: tb/tb_moore_pattern_detector.sv
// Directed bench for moore_pattern_detector: a behavioural model pushes the
// expected outputs of every edge into a scoreboard queue, popped after the edge.
module tb_moore_pattern_detector;

    logic       clk = 1'b0;
    logic       rst, din, en, load, overlap;
    logic [3:0] pattern;
    logic       y, y2;
    logic [2:0] state, state2;
    logic [7:0] cnt;
    logic [1:0] cnt2;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct { int s; int y; int cnt; int cnt_sat; } exp_t;
    exp_t sb[$];

    // Behavioural model state
    logic [3:0] m_p;
    int         m_s, m_y, m_cnt, m_cnt2;
    bit         hist[$];

    always #5 clk = ~clk;

    moore_pattern_detector #(.PATTERN_W(4), .DEFAULT_PATTERN(4'b1011), .CNT_W(8)) dut (
        .Clock(clk), .Reset(rst), .Din(din), .En(en), .Load(load),
        .Pattern(pattern), .Overlap(overlap),
        .Y(y), .State(state), .MatchCount(cnt)
    );

    moore_pattern_detector #(.PATTERN_W(4), .DEFAULT_PATTERN(4'b1011), .CNT_W(2)) dut_sat (
        .Clock(clk), .Reset(rst), .Din(din), .En(en), .Load(load),
        .Pattern(pattern), .Overlap(overlap),
        .Y(y2), .State(state2), .MatchCount(cnt2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Model one rising edge using the definition of the match length directly.
    task automatic model_edge(input logic r, input logic l, input logic e, input logic b);
        exp_t ex;
        int   ns, lim;
        bit   ok, pb;
        if (r) begin
            m_p = 4'b1011; m_s = 0; m_y = 0; m_cnt = 0; m_cnt2 = 0; hist.delete();
        end else if (l) begin
            m_p = pattern; m_s = 0; m_y = 0; hist.delete();
        end else if (e) begin
            if (m_s == 4 && !overlap) begin
                hist.delete();
                hist.push_back(b);
                ns = (b == m_p[3]) ? 1 : 0;
            end else begin
                hist.push_back(b);
                ns  = 0;
                lim = (m_s + 1 > 4) ? 4 : m_s + 1;
                for (int j = 1; j <= lim; j++) begin
                    ok = 1'b1;
                    for (int m = 0; m < j; m++) begin
                        pb = 1'(m_p >> (3 - m));
                        if (hist[hist.size() - j + m] != pb) ok = 1'b0;
                    end
                    if (ok) ns = j;
                end
            end
            m_s = ns;
            m_y = (ns == 4) ? 1 : 0;
            if (ns == 4) begin
                if (m_cnt < 255) m_cnt++;
                if (m_cnt2 < 3) m_cnt2++;
            end
        end
        ex.s = m_s; ex.y = m_y; ex.cnt = m_cnt; ex.cnt_sat = m_cnt2;
        sb.push_back(ex);
    endtask

    // Drive one cycle of stimulus, then compare both DUTs against the scoreboard.
    task automatic step(input logic r, input logic l, input logic e, input logic b);
        exp_t ex;
        rst = r; load = l; en = e; din = b;
        model_edge(r, l, e, b);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            ex = sb.pop_front();
            chk("state",     32'(state),  32'(ex.s));
            chk("y",         32'(y),      32'(ex.y));
            chk("count",     32'(cnt),    32'(ex.cnt));
            chk("sat_state", 32'(state2), 32'(ex.s));
            chk("sat_y",     32'(y2),     32'(ex.y));
            chk("sat_count", 32'(cnt2),   32'(ex.cnt_sat));
        end
    endtask

    task automatic bit_in(input logic b);
        step(1'b0, 1'b0, 1'b1, b);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [6:0] seq;
        seq = 7'b1011011;
        rst = 1'b1; load = 1'b0; en = 1'b0; din = 1'b0;
        overlap = 1'b0; pattern = 4'b0000;

        // Reset state
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_y",     32'(y),     32'd0);
        chk("reset_count", 32'(cnt),   32'd0);

        // Overlapping detection of 1011 in 1011011
        overlap = 1'b1;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 6; i >= 0; i--) begin
            bit_in(seq[i]);
            if (i == 3) chk("ovl_y_bit4", 32'(y), 32'd1);
        end
        chk("ovl_y_bit7",  32'(y),   32'd1);
        chk("ovl_count",   32'(cnt), 32'd2);

        // Non-overlapping detection of the same stream
        overlap = 1'b0;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 6; i >= 0; i--) begin
            bit_in(seq[i]);
            if (i == 3) chk("novl_y_bit4", 32'(y), 32'd1);
        end
        chk("novl_y_bit7",  32'(y),     32'd0);
        chk("novl_state7",  32'(state), 32'd1);
        chk("novl_count",   32'(cnt),   32'd1);

        // Enable gap holds the partial match
        step(1'b1, 1'b0, 1'b0, 1'b0);
        bit_in(1'b1);
        bit_in(1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'((i + 1) % 2));
            chk("gap_state", 32'(state), 32'd2);
        end
        bit_in(1'b1);
        bit_in(1'b1);
        chk("gap_y_final", 32'(y), 32'd1);

        // Load mid-match: restart with 0110, count preserved
        overlap = 1'b1;
        bit_in(1'b1);
        bit_in(1'b0);
        bit_in(1'b1);
        chk("pre_load_state", 32'(state), 32'd3);
        pattern = 4'b0110;
        step(1'b0, 1'b1, 1'b1, 1'b1);
        chk("load_state", 32'(state), 32'd0);
        chk("load_y",     32'(y),     32'd0);
        chk("load_count", 32'(cnt),   32'd1);
        bit_in(1'b0);
        bit_in(1'b1);
        bit_in(1'b1);
        bit_in(1'b0);
        chk("load_y_bit4",  32'(y),   32'd1);
        chk("load_count2",  32'(cnt), 32'd2);

        // Overlap change alone does not move S; it applies on the next exit
        overlap = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("ovchg_hold_state", 32'(state), 32'd4);
        bit_in(1'b1);
        chk("ovchg_exit_state", 32'(state), 32'd0);

        // Saturation on the 2-bit counter with 1111, overlapping
        step(1'b1, 1'b0, 1'b0, 1'b0);
        pattern = 4'b1111;
        overlap = 1'b1;
        step(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            bit_in(1'b1);
            if (i >= 4) chk("sat_y_high", 32'(y2), 32'd1);
        end
        chk("sat_count_final",  32'(cnt2), 32'd3);
        chk("wide_count_final", 32'(cnt),  32'd7);

        // Reset mid-match beats Load and En, restores default pattern
        pattern = 4'b0000;
        overlap = 1'b0;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        bit_in(1'b1);
        bit_in(1'b0);
        bit_in(1'b1);
        chk("rst_mid_pre_state", 32'(state), 32'd3);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        bit_in(1'b1);
        chk("rst_mid_state", 32'(state), 32'd1);
        chk("rst_mid_y",     32'(y),     32'd0);
        chk("rst_mid_count", 32'(cnt),   32'd0);
        bit_in(1'b0);
        bit_in(1'b1);
        bit_in(1'b1);
        chk("rst_default_pattern_y", 32'(y), 32'd1);

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
